// File: rtl/snes_audio_pkg.sv
// rtl/snes_audio_pkg.sv - shared widths, pop-state enum and saturating counter helper
package snes_audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int PAIR_W   = 32;
  localparam int CNT_W    = 8;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/snes_audio_fifo_if.sv
// rtl/snes_audio_fifo_if.sv - DSP-side, serializer-side and statistics signals of the audio FIFO
interface snes_audio_fifo_if
  import snes_audio_pkg::*;
#(
  parameter int DEPTH = 64
) ();
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic signed [SAMPLE_W-1:0] in_l;
  logic signed [SAMPLE_W-1:0] in_r;
  logic                       in_valid;
  logic                       audio_en;
  logic                       out_req;
  logic signed [SAMPLE_W-1:0] out_l;
  logic signed [SAMPLE_W-1:0] out_r;
  logic                       out_valid;
  logic [LVL_W-1:0]           level;
  logic [CNT_W-1:0]           ovf_cnt;
  logic [CNT_W-1:0]           unf_cnt;
  logic                       clr_stats;

  modport master (
    output in_l, in_r, in_valid, out_req, clr_stats,
    input  audio_en, out_l, out_r, out_valid, level, ovf_cnt, unf_cnt
  );

  modport slave (
    input  in_l, in_r, in_valid, out_req, clr_stats,
    output audio_en, out_l, out_r, out_valid, level, ovf_cnt, unf_cnt
  );
endinterface

// File: rtl/snes_audio_fifo_ram.sv
// rtl/snes_audio_fifo_ram.sv - simple dual-port sample store, synchronous write, registered read
module audio_fifo_ram
  import snes_audio_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [PAIR_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [PAIR_W-1:0]        o_rdata
);
  logic [PAIR_W-1:0] r_mem [DEPTH];
  logic [PAIR_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read-first: a pop and push to the same slot (full FIFO) returns the old entry.
  // The output register only loads on a pop, which is what holds the last sample.
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/snes_audio_fifo.sv
// rtl/snes_audio_fifo.sv - DSP-to-serializer sample FIFO with watermark throttle and underrun re-prime
module snes_audio_fifo
  import snes_audio_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int HI_WM     = 48,
  parameter int LO_WM     = 16,
  parameter int PRIME_LVL = 32
) (
  input  logic             i_wclk,
  input  logic             i_rst,
  snes_audio_fifo_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] HI_L    = (AW+1)'(HI_WM);
  localparam logic [AW:0] LO_L    = (AW+1)'(LO_WM);
  localparam logic [AW:0] PRIME_L = (AW+1)'(PRIME_LVL);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  logic [AW:0]       r_wptr, r_rptr, r_level;
  state_e            r_state;
  logic              r_audio_en, r_out_valid;
  logic [CNT_W-1:0]  r_ovf_cnt, r_unf_cnt;
  logic              w_full, w_empty, w_pop, w_push, w_drop, w_underrun;
  logic [PAIR_W-1:0] w_rdata;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop      = (r_state == ST_RUN) && bus.out_req && !w_empty;
  assign w_underrun = (r_state == ST_RUN) && bus.out_req && w_empty;
  assign w_push     = bus.in_valid && (!w_full || w_pop);
  assign w_drop     = bus.in_valid && w_full && !w_pop;

  audio_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (i_wclk),
    .i_rst   (i_rst),
    .i_we    (w_push),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata ({bus.in_l, bus.in_r}),
    .i_re    (w_pop),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_wclk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ONE;
      if (w_pop)  r_rptr <= r_rptr + ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + ONE;
        2'b01:   r_level <= r_level - ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Throttle and state look at registered LEVEL, so both lag a push by one more cycle.
  always_ff @(posedge i_wclk) begin
    if (i_rst) begin
      r_state     <= ST_PRIME;
      r_audio_en  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.out_req;
      if (r_level >= HI_L)      r_audio_en <= 1'b0;
      else if (r_level <= LO_L) r_audio_en <= 1'b1;
      case (r_state)
        ST_PRIME: if (r_level >= PRIME_L) r_state <= ST_RUN;
        ST_RUN:   if (w_underrun)         r_state <= ST_PRIME;
        default:  r_state <= ST_PRIME;
      endcase
    end
  end

  always_ff @(posedge i_wclk) begin
    if (i_rst || bus.clr_stats) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_drop)     r_ovf_cnt <= sat_inc(r_ovf_cnt);
      if (w_underrun) r_unf_cnt <= sat_inc(r_unf_cnt);
    end
  end

  assign bus.out_l     = w_rdata[PAIR_W-1:SAMPLE_W];
  assign bus.out_r     = w_rdata[SAMPLE_W-1:0];
  assign bus.out_valid = r_out_valid;
  assign bus.audio_en  = r_audio_en;
  assign bus.level     = r_level;
  assign bus.ovf_cnt   = r_ovf_cnt;
  assign bus.unf_cnt   = r_unf_cnt;
endmodule

// File: tb/tb_snes_audio_fifo.sv
// tb/tb_snes_audio_fifo.sv - randomized bench for snes_audio_fifo against a queue-based reference
module tb_snes_audio_fifo;
  localparam int DEPTH = 64;
  localparam int HI = 48;
  localparam int LO = 16;
  localparam int PR = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  snes_audio_fifo_if #(.DEPTH(DEPTH)) bus ();

  snes_audio_fifo #(.DEPTH(DEPTH), .HI_WM(HI), .LO_WM(LO), .PRIME_LVL(PR)) dut (
    .i_wclk (clk),
    .i_rst  (rst),
    .bus    (bus)
  );

  logic [31:0] q[$];
  bit          m_run, m_valid, m_en;
  logic [15:0] m_l, m_r;
  int          m_ovf, m_unf;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.out_req = 1'b0; bus.clr_stats = 1'b0;
    bus.in_l = '0; bus.in_r = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.out_req = 1'b1; bus.clr_stats = 1'b0;
    bus.in_l = 16'($urandom); bus.in_r = 16'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    q.delete(); m_run = 0; m_valid = 0; m_en = 1; m_l = '0; m_r = '0; m_ovf = 0; m_unf = 0;
  endtask

  // Apply one cycle of inputs and advance the reference by the FIFO's rules.
  task automatic step(input bit v, input logic [15:0] l, input logic [15:0] r, input bit req, input bit clr);
    int lvl;
    bit pop, unf, full;
    bus.in_valid = v; bus.in_l = l; bus.in_r = r; bus.out_req = req; bus.clr_stats = clr;
    @(posedge clk); #1;
    lvl  = q.size();
    full = (lvl == DEPTH);
    pop  = m_run && req && (lvl > 0);
    unf  = m_run && req && (lvl == 0);
    m_valid = req;
    if (pop) {m_l, m_r} = q.pop_front();
    if (v && (!full || pop)) q.push_back({l, r});
    else if (v && m_ovf < 255) m_ovf++;
    if (unf && m_unf < 255) m_unf++;
    if (clr) begin m_ovf = 0; m_unf = 0; end
    if (lvl >= HI) m_en = 0;
    else if (lvl <= LO) m_en = 1;
    if (!m_run && lvl >= PR) m_run = 1;
    else if (unf) m_run = 0;
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.out_l !== 16'd0) begin n_err++; $display("FAIL reset_out_l got=%h exp=0000", bus.out_l); end
    n_vec++; if (bus.out_r !== 16'd0) begin n_err++; $display("FAIL reset_out_r got=%h exp=0000", bus.out_r); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_vec++; if (bus.audio_en !== 1'b1) begin n_err++; $display("FAIL reset_audio_en got=%b exp=1", bus.audio_en); end
    n_vec++; if (bus.level !== 7'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    n_vec++; if (bus.ovf_cnt !== 8'd0 || bus.unf_cnt !== 8'd0) begin n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.ovf_cnt, bus.unf_cnt); end
  endtask

  task automatic test_prime_and_order();
    do_reset();
    for (int i = 0; i < 31; i++) step(1, 16'(i), 16'(-i), 0, 0);
    step(0, 16'd0, 16'd0, 1, 0);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_l !== 16'd0 || bus.out_r !== 16'd0 || bus.level !== 7'd31 || bus.unf_cnt !== 8'd0) begin
      n_err++; $display("FAIL prime_hold got=v%b l=%h r=%h lvl=%0d unf=%0d exp=v1 l=0 r=0 lvl=31 unf=0",
                        bus.out_valid, bus.out_l, bus.out_r, bus.level, bus.unf_cnt);
    end
    step(1, 16'd31, 16'(-31), 0, 0);
    step(0, 16'd0, 16'd0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      step(0, 16'd0, 16'd0, 1, 0);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_l !== 16'(i) || bus.out_r !== 16'(-i)) begin
        n_err++; $display("FAIL ordered_pop[%0d] got=v%b %h/%h exp=v1 %h/%h", i, bus.out_valid, bus.out_l, bus.out_r, 16'(i), 16'(-i));
      end
    end
    n_vec++;
    if (bus.level !== 7'd0 || bus.unf_cnt !== 8'd0) begin
      n_err++; $display("FAIL drained got=lvl%0d unf%0d exp=lvl0 unf0", bus.level, bus.unf_cnt);
    end
  endtask

  task automatic test_watermark();
    do_reset();
    for (int i = 0; i < 48; i++) begin
      step(1, 16'($urandom), 16'($urandom), 0, 0);
      n_vec++;
      if (bus.audio_en !== m_en || bus.level !== 7'(q.size())) begin
        n_err++; $display("FAIL wm_fill[%0d] got=en%b lvl%0d exp=en%b lvl%0d", i, bus.audio_en, bus.level, m_en, q.size());
      end
    end
    step(0, 16'd0, 16'd0, 0, 0);
    n_vec++; if (bus.audio_en !== 1'b0) begin n_err++; $display("FAIL wm_high got=%b exp=0", bus.audio_en); end
    while (q.size() > 16) begin
      step(0, 16'd0, 16'd0, 1, 0);
      n_vec++;
      if (bus.audio_en !== m_en || bus.out_l !== m_l || bus.out_r !== m_r) begin
        n_err++; $display("FAIL wm_drain got=en%b %h/%h exp=en%b %h/%h", bus.audio_en, bus.out_l, bus.out_r, m_en, m_l, m_r);
      end
    end
    step(0, 16'd0, 16'd0, 0, 0);
    n_vec++; if (bus.audio_en !== 1'b1) begin n_err++; $display("FAIL wm_low got=%b exp=1", bus.audio_en); end
  endtask

  task automatic test_overflow_underrun();
    logic [15:0] last_l, last_r;
    do_reset();
    for (int i = 0; i < 64; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
    n_vec++;
    if (bus.ovf_cnt !== 8'd3 || bus.level !== 7'd64) begin
      n_err++; $display("FAIL overflow got=ovf%0d lvl%0d exp=ovf3 lvl64", bus.ovf_cnt, bus.level);
    end
    step(1, 16'($urandom), 16'($urandom), 1, 0);
    n_vec++;
    if (bus.level !== 7'd64 || bus.out_l !== m_l || bus.out_r !== m_r || bus.ovf_cnt !== 8'd3) begin
      n_err++; $display("FAIL full_push_pop got=lvl%0d %h/%h ovf%0d exp=lvl64 %h/%h ovf3", bus.level, bus.out_l, bus.out_r, bus.ovf_cnt, m_l, m_r);
    end
    while (q.size() > 0) begin
      step(0, 16'd0, 16'd0, 1, 0);
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_l !== m_l || bus.out_r !== m_r) begin
        n_err++; $display("FAIL full_drain got=v%b %h/%h exp=v1 %h/%h", bus.out_valid, bus.out_l, bus.out_r, m_l, m_r);
      end
    end
    last_l = m_l; last_r = m_r;
    step(0, 16'd0, 16'd0, 1, 0);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_l !== last_l || bus.out_r !== last_r || bus.unf_cnt !== 8'd1) begin
      n_err++; $display("FAIL underrun got=v%b %h/%h unf%0d exp=v1 %h/%h unf1", bus.out_valid, bus.out_l, bus.out_r, bus.unf_cnt, last_l, last_r);
    end
    step(0, 16'd0, 16'd0, 1, 0);
    n_vec++; if (bus.unf_cnt !== 8'd1) begin n_err++; $display("FAIL reprime_no_count got=%0d exp=1", bus.unf_cnt); end
    for (int k = 1; k < 300; k++) begin
      for (int i = 0; i < 32; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
      step(0, 16'd0, 16'd0, 0, 0);
      for (int i = 0; i < 33; i++) step(0, 16'd0, 16'd0, 1, 0);
    end
    n_vec++; if (bus.unf_cnt !== 8'd255) begin n_err++; $display("FAIL unf_saturate got=%0d exp=255", bus.unf_cnt); end
    step(0, 16'd0, 16'd0, 0, 1);
    n_vec++;
    if (bus.unf_cnt !== 8'd0 || bus.ovf_cnt !== 8'd0) begin
      n_err++; $display("FAIL clr_stats got=ovf%0d unf%0d exp=0/0", bus.ovf_cnt, bus.unf_cnt);
    end
  endtask

  task automatic test_random();
    logic [56:0] obs, expv;
    int push_pct, pop_pct;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        push_pct = $urandom_range(10, 95);
        pop_pct  = $urandom_range(10, 95);
      end
      step($urandom_range(0, 99) < push_pct, 16'($urandom), 16'($urandom),
           $urandom_range(0, 99) < pop_pct, $urandom_range(0, 63) == 0);
      obs  = {bus.out_l, bus.out_r, bus.out_valid, bus.level, bus.audio_en, bus.ovf_cnt, bus.unf_cnt};
      expv = {m_l, m_r, m_valid, 7'(q.size()), m_en, 8'(m_ovf), 8'(m_unf)};
      n_vec++;
      if (obs !== expv) begin
        n_err++; $display("FAIL random[%0d] got=%h exp=%h", c, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
    step(0, 16'd0, 16'd0, 0, 0);
    step(0, 16'd0, 16'd0, 1, 0);
    n_vec++; if (bus.level !== 7'd39) begin n_err++; $display("FAIL mid_level got=%0d exp=39", bus.level); end
    do_reset();
    n_vec++;
    if (bus.out_l !== 16'd0 || bus.out_r !== 16'd0 || bus.out_valid !== 1'b0 || bus.level !== 7'd0 || bus.audio_en !== 1'b1) begin
      n_err++; $display("FAIL mid_reset got=%h/%h v%b lvl%0d en%b exp=0/0 v0 lvl0 en1",
                        bus.out_l, bus.out_r, bus.out_valid, bus.level, bus.audio_en);
    end
    step(0, 16'd0, 16'd0, 1, 0);
    n_vec++;
    if (bus.out_l !== 16'd0 || bus.unf_cnt !== 8'd0 || bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL post_reset_prime got=%h unf%0d v%b exp=0 unf0 v1", bus.out_l, bus.unf_cnt, bus.out_valid);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_prime_and_order();
    test_watermark();
    test_overflow_underrun();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
